// File: rtl/gpu_ctrl_pkg.sv
// Shared opcode values and FSM state encoding for the GPU instruction sequencer.
package gpu_ctrl_pkg;

  localparam int unsigned OP_WBR = 0;
  localparam int unsigned OP_WSM = 1;
  localparam int unsigned OP_WBM = 2;
  localparam int unsigned OP_DP  = 3;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DECODE   = 3'd1,
    ST_REG_WR   = 3'd2,
    ST_MEM_WAIT = 3'd3,
    ST_MEM_WR   = 3'd4,
    ST_POLY     = 3'd5,
    ST_ERR      = 3'd6
  } state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with head-of-queue read data and full/empty flags.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (AW + 1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign dout_o  = mem_q[rd_ptr_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // DEPTH is a power of two, so natural pointer overflow wraps modulo DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/gpu_sequencer.sv
// Queues host opcodes and steps each through decode, register/memory write or polygon wait.
module gpu_sequencer
  import gpu_ctrl_pkg::*;
#(
  parameter int OPCODE_W   = 4,
  parameter int FIELD_W    = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opCode,
  input  logic                instr_valid,
  output logic                instr_ready,
  input  logic                printtingScreen,
  input  logic                done,
  output logic                new_instruction,
  output logic                memory_wr,
  output logic                register_wr,
  output logic                selectorDemuxRegister,
  output logic                selectorDemuxData,
  output logic                selectorAddress,
  output logic [FIELD_W-1:0]  selectField,
  output logic                busy,
  output logic                error,
  output logic [2:0]          dbg_state
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam int EXT_W = (OPCODE_W > FIELD_W) ? OPCODE_W : FIELD_W;

  state_e              state_q, state_d;
  logic [OPCODE_W-1:0] op_q, op_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [OPCODE_W-1:0] fifo_dout;
  logic [EXT_W-1:0]    op_ext;

  // Handshake: an opcode transfers on a rising edge where instr_valid and
  // instr_ready are both high; instr_ready depends only on queue fullness and
  // reset, never on instr_valid, and a refused offer leaves the queue untouched.
  assign instr_ready = reset & ~fifo_full;
  assign fifo_push   = instr_valid & instr_ready;
  assign fifo_pop    = reset & (state_q == ST_IDLE) & ~fifo_empty;
  assign dbg_state   = state_q;

  sync_fifo #(
    .WIDTH (OPCODE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (fifo_push),
    .din_i   (opCode),
    .pop_i   (fifo_pop),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = '0;
    case (state_q)
      ST_IDLE: begin
        if (fifo_pop) begin
          op_d    = fifo_dout;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (op_q == OPCODE_W'(OP_WBR)) begin
          state_d = ST_REG_WR;
        end else if ((op_q == OPCODE_W'(OP_WSM)) || (op_q == OPCODE_W'(OP_WBM))) begin
          state_d = ST_MEM_WAIT;
        end else if (op_q == OPCODE_W'(OP_DP)) begin
          state_d = ST_POLY;
        end else begin
          state_d = ST_ERR;
        end
      end
      ST_REG_WR: state_d = ST_IDLE;
      ST_MEM_WAIT: begin
        if (!printtingScreen) state_d = ST_MEM_WR;
      end
      ST_MEM_WR: state_d = ST_IDLE;
      ST_POLY: begin
        // done wins over a timeout expiring in the same cycle.
        if (done) begin
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d = ST_ERR;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
    end
  end

  assign op_ext = EXT_W'(op_q);

  // Outputs are forced low while reset is held so nothing leaks before the first edge.
  always_comb begin
    new_instruction       = fifo_pop;
    memory_wr             = 1'b0;
    register_wr           = 1'b0;
    selectorDemuxRegister = 1'b0;
    selectorDemuxData     = 1'b0;
    selectorAddress       = 1'b0;
    error                 = 1'b0;
    selectField           = '0;
    busy                  = reset & ((state_q != ST_IDLE) | ~fifo_empty);
    if (reset) begin
      if (state_q != ST_IDLE) selectField = op_ext[FIELD_W-1:0];
      case (state_q)
        ST_REG_WR: register_wr = 1'b1;
        ST_MEM_WR: begin
          memory_wr       = 1'b1;
          selectorAddress = (op_q == OPCODE_W'(OP_WBM));
        end
        ST_POLY: begin
          register_wr           = 1'b1;
          selectorDemuxRegister = 1'b1;
          selectorDemuxData     = 1'b1;
        end
        ST_ERR:  error = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gpu_sequencer.sv
// Directed and randomized checks of gpu_sequencer against an instruction-level model.
module tb_gpu_sequencer;

  localparam int OPCODE_W   = 4;
  localparam int FIELD_W    = 4;
  localparam int FIFO_DEPTH = 4;
  localparam int TIMEOUT    = 8;

  // Model phases of the instruction currently being executed.
  localparam int PH_IDLE   = 0;
  localparam int PH_DECODE = 1;
  localparam int PH_EXEC   = 2;
  localparam int PH_MEMWR  = 3;
  localparam int PH_TOERR  = 4;

  localparam int K_REG  = 0;
  localparam int K_MEM  = 1;
  localparam int K_POLY = 2;
  localparam int K_ILL  = 3;

  logic                clk = 1'b0;
  logic                reset = 1'b0;
  logic [OPCODE_W-1:0] opCode = '0;
  logic                instr_valid = 1'b0;
  logic                printtingScreen = 1'b0;
  logic                done = 1'b0;
  logic                instr_ready, new_instruction, memory_wr, register_wr;
  logic                selectorDemuxRegister, selectorDemuxData, selectorAddress;
  logic [FIELD_W-1:0]  selectField;
  logic                busy, error;
  logic [2:0]          dbg_state;

  gpu_sequencer #(
    .OPCODE_W   (OPCODE_W),
    .FIELD_W    (FIELD_W),
    .FIFO_DEPTH (FIFO_DEPTH),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk                   (clk),
    .reset                 (reset),
    .opCode                (opCode),
    .instr_valid           (instr_valid),
    .instr_ready           (instr_ready),
    .printtingScreen       (printtingScreen),
    .done                  (done),
    .new_instruction       (new_instruction),
    .memory_wr             (memory_wr),
    .register_wr           (register_wr),
    .selectorDemuxRegister (selectorDemuxRegister),
    .selectorDemuxData     (selectorDemuxData),
    .selectorAddress       (selectorAddress),
    .selectField           (selectField),
    .busy                  (busy),
    .error                 (error),
    .dbg_state             (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard / model state ----------------
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [OPCODE_W-1:0] exp_q[$];
  int m_phase = PH_IDLE;
  logic [OPCODE_W-1:0] m_op = '0;
  int m_poly = 0;
  logic [12:0] obs;
  int n_memwr = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  function automatic int kind(input logic [OPCODE_W-1:0] op);
    case (op)
      4'd0:       return K_REG;
      4'd1, 4'd2: return K_MEM;
      4'd3:       return K_POLY;
      default:    return K_ILL;
    endcase
  endfunction

  // Bit map: 12 new,11 mem_wr,10 reg_wr,9 dmx_reg,8 dmx_data,7 addr,6 busy,5 err,4 ready,3:0 field.
  function automatic logic [12:0] model_out();
    logic [12:0] e;
    e = '0;
    if (!reset) return e;
    e[4] = (exp_q.size() < FIFO_DEPTH);
    if (m_phase == PH_IDLE) begin
      e[12] = (exp_q.size() > 0);
      e[6]  = (exp_q.size() > 0);
    end else begin
      e[6]   = 1'b1;
      e[3:0] = m_op;
      if (m_phase == PH_EXEC) begin
        case (kind(m_op))
          K_REG:  e[10] = 1'b1;
          K_POLY: begin e[10] = 1'b1; e[9] = 1'b1; e[8] = 1'b1; end
          K_ILL:  e[5] = 1'b1;
          default: ;
        endcase
      end else if (m_phase == PH_MEMWR) begin
        e[11] = 1'b1;
        e[7]  = (m_op == 4'd2);
      end else if (m_phase == PH_TOERR) begin
        e[5] = 1'b1;
      end
    end
    return e;
  endfunction

  task automatic model_edge();
    bit acc;
    if (!reset) begin
      exp_q.delete();
      m_phase = PH_IDLE;
      m_poly  = 0;
      return;
    end
    acc = instr_valid && (exp_q.size() < FIFO_DEPTH);
    case (m_phase)
      PH_IDLE: begin
        if (exp_q.size() > 0) begin
          m_op    = exp_q.pop_front();
          m_phase = PH_DECODE;
        end
      end
      PH_DECODE: begin
        m_phase = PH_EXEC;
        m_poly  = 0;
      end
      PH_EXEC: begin
        case (kind(m_op))
          K_MEM: if (!printtingScreen) m_phase = PH_MEMWR;
          K_POLY: begin
            if (done) m_phase = PH_IDLE;
            else begin
              m_poly++;
              if (m_poly >= TIMEOUT) m_phase = PH_TOERR;
            end
          end
          default: m_phase = PH_IDLE;
        endcase
      end
      default: m_phase = PH_IDLE;
    endcase
    if (acc) exp_q.push_back(opCode);
  endtask

  // ---------------- driver tasks ----------------
  // One clock cycle: sample at negedge, compare to model, advance model, resume after posedge.
  task automatic tick();
    logic [12:0] e;
    @(negedge clk);
    obs = {new_instruction, memory_wr, register_wr, selectorDemuxRegister, selectorDemuxData,
           selectorAddress, busy, error, instr_ready, selectField};
    e = model_out();
    check("outs", 32'(obs), 32'(e));
    n_memwr += int'(obs[11]);
    n_err   += int'(obs[5]);
    model_edge();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic push_op(input logic [OPCODE_W-1:0] op);
    instr_valid = 1'b1;
    opCode      = op;
    tick();
    instr_valid = 1'b0;
  endtask

  task automatic idle_wait();
    int n;
    n = 0;
    while ((m_phase != PH_IDLE || exp_q.size() != 0) && n < 300) begin
      tick();
      n++;
    end
    check("idle_wait_bound", 32'(n < 300), 32'(1));
    check("idle_busy", 32'(busy), 32'(0));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int err_cnt, err_at, poly_cnt, wr_seen, sf_at_err;
    logic [3:0] ready_seen;
    logic [OPCODE_W-1:0] burst [5];
    burst[0] = 4'd0; burst[1] = 4'd2; burst[2] = 4'd3; burst[3] = 4'd15; burst[4] = 4'd1;

    // Reset behaviour
    reset = 1'b0;
    instr_valid = 1'b1;
    opCode = 4'd0;
    repeat (3) tick();
    check("rst_outs", 32'(obs), 32'(0));
    instr_valid = 1'b0;
    reset = 1'b1;
    tick();
    check("ready_after_rst", 32'(obs[4]), 32'(1));
    check("busy_after_rst", 32'(obs[6]), 32'(0));

    // WBR latency
    push_op(4'd0);
    tick(); check("wbr_new_instr", 32'(obs[12]), 32'(1));
    tick(); check("wbr_not_early", 32'(obs[10]), 32'(0));
    tick(); check("wbr_reg_wr", 32'(obs[10]), 32'(1));
    check("wbr_demux", 32'(obs[9]), 32'(0));
    check("wbr_field", 32'(obs[3:0]), 32'(0));
    tick(); check("wbr_one_cycle", 32'(obs[10]), 32'(0));

    // WSM latency with screen idle
    push_op(4'd1);
    repeat (3) tick();
    check("wsm_not_early", 32'(obs[11]), 32'(0));
    tick();
    check("wsm_mem_wr", 32'(obs[11]), 32'(1));
    check("wsm_addr", 32'(obs[7]), 32'(0));
    idle_wait();

    // WBM held off by screen scan for 10 cycles
    printtingScreen = 1'b1;
    push_op(4'd2);
    wr_seen = 0;
    repeat (9) begin tick(); wr_seen += int'(obs[11]); end
    check("wbm_hold", 32'(wr_seen), 32'(0));
    printtingScreen = 1'b0;
    tick(); check("wbm_fall_cycle", 32'(obs[11]), 32'(0));
    tick();
    check("wbm_mem_wr", 32'(obs[11]), 32'(1));
    check("wbm_addr", 32'(obs[7]), 32'(1));
    check("wbm_field", 32'(obs[3:0]), 32'(2));
    idle_wait();

    // DP timeout
    done = 1'b0;
    push_op(4'd3);
    err_cnt = 0; err_at = -1; poly_cnt = 0;
    for (int i = 1; i <= 11; i++) begin
      tick();
      if (obs[5]) begin err_cnt++; err_at = i; end
      if (obs[8]) poly_cnt++;
    end
    check("dp_err_once", 32'(err_cnt), 32'(1));
    check("dp_err_tick", 32'(err_at), 32'(11));
    check("dp_poly_cycles", 32'(poly_cnt), 32'(TIMEOUT));
    tick();
    check("dp_busy_falls", 32'(obs[6]), 32'(0));

    // Illegal opcode
    push_op(4'd15);
    err_cnt = 0; wr_seen = 0; sf_at_err = 0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      wr_seen += int'(obs[11] | obs[10]);
      if (obs[5]) begin err_cnt++; sf_at_err = int'(obs[3:0]); end
    end
    check("ill_err_once", 32'(err_cnt), 32'(1));
    check("ill_no_writes", 32'(wr_seen), 32'(0));
    check("ill_field", 32'(sf_at_err), 32'(15));

    // Full queue while stalled in MEM_WAIT
    printtingScreen = 1'b1;
    push_op(4'd1);
    repeat (3) tick();
    for (int i = 0; i < 5; i++) begin
      instr_valid = 1'b1;
      opCode = burst[i];
      tick();
      if (i < 4) ready_seen[i] = obs[4];
      else check("full_ready_low", 32'(obs[4]), 32'(0));
    end
    instr_valid = 1'b0;
    check("full_ready_first4", 32'(ready_seen), 32'(4'hf));
    printtingScreen = 1'b0;
    done = 1'b1;
    n_memwr = 0; n_err = 0;
    idle_wait();
    check("full_mem_writes", 32'(n_memwr), 32'(2));
    check("full_errors", 32'(n_err), 32'(1));

    // Reset during POLY with a WBR queued behind it
    done = 1'b0;
    push_op(4'd3);
    push_op(4'd0);
    repeat (3) tick();
    check("poly_active", 32'(obs[8]), 32'(1));
    reset = 1'b0;
    tick();
    check("rst_mid_outs", 32'(obs), 32'(0));
    reset = 1'b1;
    tick();
    check("rst_mid_after", 32'(obs), 32'(13'h010));
    done = 1'b1;
    push_op(4'd0);
    repeat (2) tick();
    tick(); check("rst_mid_wbr", 32'(obs[10]), 32'(1));
    idle_wait();

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      int r;
      instr_valid = ($urandom_range(0, 2) == 0);
      r = int'($urandom_range(0, 9));
      opCode = (r <= 6) ? OPCODE_W'(r % 4) : OPCODE_W'($urandom_range(4, 15));
      printtingScreen = ($urandom_range(0, 2) == 0);
      done = ($urandom_range(0, 5) == 0);
      reset = ($urandom_range(0, 199) != 0);
      tick();
    end
    reset = 1'b1;
    instr_valid = 1'b0;
    printtingScreen = 1'b0;
    done = 1'b1;
    idle_wait();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gpu_sequencer.md
GPU_SEQUENCER -- requirements
Module: gpu_sequencer

Interface
REQ-001 SHALL have parameter OPCODE_W, default 4, opcode width (>=4).
REQ-002 SHALL have parameter FIELD_W, default 4, selectField width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, instruction queue depth (power of 2, >=2).
REQ-004 SHALL have parameter TIMEOUT, default 255, max cycles spent waiting for done.
REQ-005 SHALL have port clk  in  1  the only clock; all logic updates on the rising edge.
REQ-006 SHALL have port reset  in  1  synchronous, active-low reset.
REQ-007 SHALL have port opCode  in  OPCODE_W  instruction opcode offered by the host.
REQ-008 SHALL have port instr_valid  in  1  opCode is valid this cycle.
REQ-009 SHALL have port instr_ready  out  1  queue can accept a push; equals not-full.
REQ-010 SHALL have port printtingScreen  in  1  video scan active; memory writes are forbidden while high.
REQ-011 SHALL have port done  in  1  polygon co-processor has finished.
REQ-012 SHALL have outputs new_instruction, memory_wr, register_wr, selectorDemuxRegister, selectorDemuxData, selectorAddress (1 bit each), selectField (FIELD_W), busy (1), error (1).

Function
REQ-013 SHALL push opCode into the FIFO on any rising edge with instr_valid=1 and instr_ready=1.
REQ-014 SHALL implement FSM states IDLE, DECODE, REG_WR, MEM_WAIT, MEM_WR, POLY, ERR.
REQ-015 IDLE: when the FIFO is non-empty, SHALL pop one entry, pulse new_instruction for exactly 1 cycle, and go to DECODE; otherwise SHALL stay in IDLE.
REQ-016 DECODE SHALL dispatch on the popped opcode: 0 (WBR) -> REG_WR; 1 (WSM) and 2 (WBM) -> MEM_WAIT; 3 (DP) -> POLY; any other value -> ERR.
REQ-017 REG_WR SHALL assert register_wr=1 with selectorDemuxRegister=0 for 1 cycle, then go to IDLE.
REQ-018 MEM_WAIT SHALL hold while printtingScreen=1 and go to MEM_WR on the first cycle in which printtingScreen=0.
REQ-019 MEM_WR SHALL assert memory_wr=1 for 1 cycle, with selectorAddress=0 for WSM and 1 for WBM, then go to IDLE.
REQ-020 POLY SHALL hold register_wr=1, selectorDemuxRegister=1 and selectorDemuxData=1 until done=1, then go to IDLE.
REQ-021 POLY SHALL count cycles; if done stays 0 for TIMEOUT cycles, the FSM SHALL go to ERR instead.
REQ-022 ERR SHALL pulse error=1 for 1 cycle, then go to IDLE; an illegal opcode SHALL produce no memory or register write.
REQ-023 selectField SHALL carry the low FIELD_W bits of the active opcode (zero-extended if OPCODE_W<FIELD_W) from DECODE through the final state of that instruction, and SHALL be 0 in IDLE.
REQ-024 busy SHALL be 1 in every state except IDLE, and SHALL also be 1 in IDLE while the FIFO is non-empty.
REQ-025 Minimum latency from push (queue empty, FSM idle) to register_wr SHALL be 3 rising edges; to memory_wr it SHALL be 4 rising edges when printtingScreen=0.
REQ-026 When the FIFO is full, instr_ready SHALL be 0, and a valid offer SHALL be neither stored nor able to overwrite an entry.
REQ-027 A push and a pop in the same cycle SHALL both take effect, leaving the count unchanged.
REQ-028 FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-029 done=1 outside POLY SHALL be ignored; done and the timeout expiring in the same cycle SHALL resolve as done (go to IDLE, no error).

Reset
REQ-030 On a rising edge with reset=0, the FSM SHALL go to IDLE, the FIFO SHALL flush, and the timeout counter SHALL clear.
REQ-031 While in reset, all outputs SHALL be 0 except instr_ready, which SHALL be 0 during reset and 1 on the first cycle after release.
REQ-032 Reset asserted mid-instruction SHALL abort the instruction with no further write pulses.

Structure
REQ-033 Package gpu_ctrl_pkg SHALL hold the opcode constants (WBR=0, WSM=1, WBM=2, DP=3) and the FSM state enumeration.
REQ-034 The queue SHALL be a sub-module, sync_fifo, parametrised by width and depth and exposing full/empty.

Verification
REQ-035 Push WBR into an idle block -> new_instruction at edge 1, register_wr=1 for one cycle at edge 3, selectField=0000.
REQ-036 Push WBM with printtingScreen=1 for 10 cycles -> no memory_wr during those cycles; memory_wr=1 and selectorAddress=1 on the first cycle after printtingScreen falls.
REQ-037 Push DP with done held at 0 and TIMEOUT=8 -> error pulses once after 8 POLY cycles, then busy falls.
REQ-038 Push opcode 1111 -> error=1 for one cycle, with memory_wr=register_wr=0 throughout.
REQ-039 Push 5 entries back-to-back with FIFO_DEPTH=4 while the FSM is stalled in MEM_WAIT -> instr_ready drops after 4 entries; all stored entries then execute in order.
REQ-040 Assert reset=0 during POLY -> all outputs 0 on the next edge and FIFO empty; after release, a new WBR executes normally.
